// File: rtl/fsm_phase_monitor.sv
// fsm_phase_monitor
//
// Downstream checker for the four-phase control FSM. It samples the
// upstream registered outputs {dout_q, dout_p} and decodes them as a
// phase. It checks that phases follow IDLE->S1->S2->S3->IDLE and
// measures how long each active phase is held. It counts completed
// cycles and keeps sticky sequence and length error flags.
//
// Optional build macro: FSM_MON_TIMEOUT_EN
//   When defined, an active phase held for more than MAX_LEN cycles
//   raises len_err while it is still held. When undefined, an
//   over-length phase is only flagged when it exits.
//
// Parameters
//   LEN_W    width of the phase-length counter and of last_len
//   CNT_W    width of cycle_cnt
//   MIN_LEN  minimum legal active-phase length (cycles)
//   MAX_LEN  maximum legal active-phase length (cycles), <= 2^LEN_W-2
//
// Ports
//   clk         system clock, posedge
//   rst_n       asynchronous active-low reset
//   dout_p      p output of the upstream FSM
//   dout_q      q output of the upstream FSM
//   clr         synchronous clear of seq_err, len_err and cycle_cnt
//   phase       registered phase {q,p}: 00 IDLE, 01 S1, 10 S2, 11 S3
//   busy        registered phase is not IDLE
//   cycle_done  one-cycle pulse after a legal S3->IDLE
//   cycle_cnt   completed legal cycles, wraps
//   last_len    length of the most recently exited active phase
//   seq_err     sticky illegal-transition flag
//   len_err     sticky out-of-range-length flag

module fsm_phase_monitor #(
  parameter int LEN_W   = 6,
  parameter int CNT_W   = 8,
  parameter int MIN_LEN = 1,
  parameter int MAX_LEN = 17
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             dout_p,
  input  logic             dout_q,
  input  logic             clr,
  output logic [1:0]       phase,
  output logic             busy,
  output logic             cycle_done,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [LEN_W-1:0] last_len,
  output logic             seq_err,
  output logic             len_err
);

  typedef enum logic [2:0] {
    M_IDLE = 3'd0,
    M_S1   = 3'd1,
    M_S2   = 3'd2,
    M_S3   = 3'd3,
    M_ERR  = 3'd4
  } mon_state_t;

  // Length limits sized to the counter so comparisons stay width-matched.
  localparam logic [LEN_W-1:0] MIN_L   = LEN_W'(MIN_LEN);
  localparam logic [LEN_W-1:0] MAX_L   = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] LEN_SAT = {LEN_W{1'b1}};

  localparam logic [1:0] PH_IDLE = 2'b00;
  localparam logic [1:0] PH_S1   = 2'b01;
  localparam logic [1:0] PH_S2   = 2'b10;
  localparam logic [1:0] PH_S3   = 2'b11;

  mon_state_t       state_reg, state_next;
  logic [1:0]       ph_reg;
  logic [LEN_W-1:0] run_len_reg, run_len_next;
  logic [LEN_W-1:0] last_len_reg, last_len_next;
  logic [CNT_W-1:0] cycle_cnt_reg, cycle_cnt_next;
  logic             cycle_done_reg, cycle_done_next;
  logic             seq_err_reg, seq_err_next;
  logic             len_err_reg, len_err_next;

  logic [1:0]       in_ph;
  logic             change;
  logic             active;
  logic             len_bad;
  logic             seq_set;
  logic             len_set;

  assign in_ph   = {dout_q, dout_p};
  assign change  = (in_ph != ph_reg);
  assign active  = (ph_reg != PH_IDLE);
  assign len_bad = (run_len_reg < MIN_L) || (run_len_reg > MAX_L);

  // Tracker state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= M_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state, error detection and counter updates.
  always_comb begin
    state_next      = state_reg;
    seq_set         = 1'b0;
    len_set         = 1'b0;
    cycle_done_next = 1'b0;
    last_len_next   = last_len_reg;
    run_len_next    = run_len_reg;

    // run_len restarts at 1 on the cycle the new phase is first seen.
    if (change) begin
      run_len_next = LEN_W'(1);
    end else if (run_len_reg != LEN_SAT) begin
      run_len_next = run_len_reg + LEN_W'(1);
    end

    case (state_reg)
      M_IDLE: begin
        if (change) begin
          if (in_ph == PH_S1) begin
            state_next = M_S1;
          end else begin
            state_next = M_ERR;
            seq_set    = 1'b1;
          end
        end
      end
      M_S1: begin
        if (change) begin
          if (in_ph == PH_S2) begin
            state_next = M_S2;
          end else begin
            state_next = M_ERR;
            seq_set    = 1'b1;
          end
        end
      end
      M_S2: begin
        if (change) begin
          if (in_ph == PH_S3) begin
            state_next = M_S3;
          end else begin
            state_next = M_ERR;
            seq_set    = 1'b1;
          end
        end
      end
      M_S3: begin
        if (change) begin
          if (in_ph == PH_IDLE) begin
            state_next      = M_IDLE;
            cycle_done_next = 1'b1;
          end else begin
            state_next = M_ERR;
            seq_set    = 1'b1;
          end
        end
      end
      M_ERR: begin
        // Resynchronise on the next observed IDLE; no further seq_err here.
        if (in_ph == PH_IDLE) begin
          state_next = M_IDLE;
        end
      end
      default: begin
        state_next = M_IDLE;
      end
    endcase

    // Exit check on any phase leaving an active phase, legal or not.
    if (change && active) begin
      last_len_next = run_len_reg;
      if (len_bad) begin
        len_set = 1'b1;
      end
    end

`ifdef FSM_MON_TIMEOUT_EN
    // Flag a stalled phase on the edge where run_len would pass MAX_LEN.
    if (!change && active && (run_len_reg == MAX_L)) begin
      len_set = 1'b1;
    end
`endif

    // Sticky flags: a new error in the clear cycle wins over clr.
    seq_err_next = seq_set | (seq_err_reg & ~clr);
    len_err_next = len_set | (len_err_reg & ~clr);

    // A completion in the clear cycle counts as the first of the new count.
    if (cycle_done_next) begin
      cycle_cnt_next = clr ? CNT_W'(1) : cycle_cnt_reg + CNT_W'(1);
    end else begin
      cycle_cnt_next = clr ? '0 : cycle_cnt_reg;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph_reg         <= PH_IDLE;
      run_len_reg    <= '0;
      last_len_reg   <= '0;
      cycle_cnt_reg  <= '0;
      cycle_done_reg <= 1'b0;
      seq_err_reg    <= 1'b0;
      len_err_reg    <= 1'b0;
    end else begin
      ph_reg         <= in_ph;
      run_len_reg    <= run_len_next;
      last_len_reg   <= last_len_next;
      cycle_cnt_reg  <= cycle_cnt_next;
      cycle_done_reg <= cycle_done_next;
      seq_err_reg    <= seq_err_next;
      len_err_reg    <= len_err_next;
    end
  end

  assign phase      = ph_reg;
  assign busy       = (ph_reg != PH_IDLE);
  assign cycle_done = cycle_done_reg;
  assign cycle_cnt  = cycle_cnt_reg;
  assign last_len   = last_len_reg;
  assign seq_err    = seq_err_reg;
  assign len_err    = len_err_reg;

endmodule
